// File: rtl/vga_pkg.sv
// Purpose: shared VGA 640x480@60 raster constants and small types for the display fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  // Raster counter widths (800 and 525 both fit in 10 bits)
  localparam int H_W = 10;
  localparam int V_W = 10;

  // Horizontal timing, in pixel clocks
  localparam logic [H_W-1:0] H_ACTIVE = 10'd640;
  localparam logic [H_W-1:0] H_FP     = 10'd16;
  localparam logic [H_W-1:0] H_SYNC   = 10'd96;
  localparam logic [H_W-1:0] H_TOTAL  = 10'd800;

  // Vertical timing, in lines
  localparam logic [V_W-1:0] V_ACTIVE = 10'd480;
  localparam logic [V_W-1:0] V_FP     = 10'd10;
  localparam logic [V_W-1:0] V_SYNC   = 10'd2;
  localparam logic [V_W-1:0] V_TOTAL  = 10'd525;

  // Sync pulse windows: [BEG, END)
  localparam logic [H_W-1:0] H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam logic [H_W-1:0] H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam logic [V_W-1:0] V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam logic [V_W-1:0] V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

  // Framebuffer geometry: 160x120 bytes, one byte per 4x4 pixel block
  localparam int             ROW_W     = 15;
  localparam logic [ROW_W-1:0] FB_STRIDE = 15'd160;

  // Counters -> address -> RAM data -> rgb register
  localparam int PIPE_DEPTH = 3;

  // Raw or delayed sync/active flags travelling alongside the pixel data
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  // Who owns port B in a given cycle
  typedef enum logic [1:0] {
    PB_IDLE  = 2'd0,
    PB_FETCH = 2'd1,
    PB_WRITE = 2'd2
  } pb_sel_e;

endpackage

// File: rtl/vga_timing_gen.sv
// Purpose: free-running 800x525 raster counters with raw hsync/vsync/active flags.
// Latency: h/v are registered; sync_raw, fetch_now and the wrap flags are combinational from them.
// Backpressure: none, the raster never stalls.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           h_last,
  output logic           v_last,
  output logic           fetch_now,
  output sync_t          sync_raw
);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  assign h = h_q;
  assign v = v_q;

  // Next raster position: h wraps at end of line and carries into v, v wraps at end of frame.
  always_comb begin
    h_last = (h_q == H_TOTAL - H_W'(1));
    v_last = (v_q == V_TOTAL - V_W'(1));
    h_d    = h_q + H_W'(1);
    v_d    = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + V_W'(1);
    end
  end

  // Raw flags for the current raster position, before any pipeline alignment.
  always_comb begin
    fetch_now   = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    sync_raw.hs = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    sync_raw.vs = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
    sync_raw.de = fetch_now;
  end

  // Raster counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/vga_fetch.sv
// Purpose: VGA scan-out client of framebuffer port B; fetches 1 byte per 4x4 block, lets IO writes in during blanking.
// Latency: counters(t) -> mem_addr(t+1) -> mem_dout(t+2) -> rgb/de/hs/vs(t+3).
// Backpressure: io_req is held until io_ack; the display always wins port B while fetching, at most one write per 2 clks.
module vga_fetch
  import vga_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] FB_BASE = 16'h8000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [7:0]        io_data,
  output logic              io_ack,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic [2:0]        vga_r,
  output logic [2:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              vga_de
);

  // Raster position and raw flags
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           h_last;
  logic           v_last;
  logic           fetch_now;
  sync_t          sync_raw;

  vga_timing_gen u_tg (
    .clk       (clk),
    .rst       (rst),
    .h         (h),
    .v         (v),
    .h_last    (h_last),
    .v_last    (v_last),
    .fetch_now (fetch_now),
    .sync_raw  (sync_raw)
  );

  // Byte offset of the framebuffer row for the current line (row * 160), kept incrementally.
  logic [ROW_W-1:0]  row_base_q, row_base_d;

  // Port B registers
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic              io_ack_q, io_ack_d;
  logic [ADDR_W-1:0] fetch_addr;
  pb_sel_e           pb_sel;

  // Sync/active delay line and pixel register
  sync_t [PIPE_DEPTH-1:0] pipe_q, pipe_d;
  logic [7:0]             rgb_q, rgb_d;

  // Row base: step by one framebuffer row after every 4th active line, restart at frame end.
  always_comb begin
    row_base_d = row_base_q;
    if (h_last) begin
      if (v_last) begin
        row_base_d = '0;
      end else if ((v[1:0] == 2'b11) && (v < V_ACTIVE)) begin
        row_base_d = row_base_q + FB_STRIDE;
      end
    end
  end

  // Port B owner: display fetch first, then a not-yet-acked IO write, otherwise idle.
  always_comb begin
    fetch_addr = FB_BASE + ADDR_W'(row_base_q) + ADDR_W'(h >> 2);
    pb_sel     = PB_IDLE;
    if (fetch_now) begin
      pb_sel = PB_FETCH;
    end else if (io_req && !io_ack_q) begin
      // io_ack_q blocks a second write of the same request in its ack cycle
      pb_sel = PB_WRITE;
    end
  end

  // Port B next-state: address and data hold when idle, strobes are single-cycle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    io_ack_d   = 1'b0;
    case (pb_sel)
      PB_FETCH: begin
        mem_addr_d = fetch_addr;
      end
      PB_WRITE: begin
        mem_addr_d = io_addr;
        mem_din_d  = io_data;
        mem_we_d   = 1'b1;
        io_ack_d   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Delay flags to match the address + RAM read stages; blank rgb outside active video.
  always_comb begin
    pipe_d[0] = sync_raw;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    // pipe_q[PIPE_DEPTH-2] is the flag for the byte now on mem_dout
    rgb_d = pipe_q[PIPE_DEPTH-2].de ? mem_dout : 8'h00;
  end

  // All state registers; reset drops any in-flight IO request without acking it.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      io_ack_q   <= 1'b0;
      pipe_q     <= {PIPE_DEPTH{SYNC_IDLE}};
      rgb_q      <= '0;
    end else begin
      row_base_q <= row_base_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      io_ack_q   <= io_ack_d;
      pipe_q     <= pipe_d;
      rgb_q      <= rgb_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign io_ack   = io_ack_q;

  assign vga_hs = pipe_q[PIPE_DEPTH-1].hs;
  assign vga_vs = pipe_q[PIPE_DEPTH-1].vs;
  assign vga_de = pipe_q[PIPE_DEPTH-1].de;
  assign vga_r  = rgb_q[7:5];
  assign vga_g  = rgb_q[4:2];
  assign vga_b  = rgb_q[1:0];

endmodule

// File: tb/tb_vga_fetch.sv
// Purpose: directed self-checking bench for vga_fetch with a registered-read RAM model on port B.
// Latency: outputs sampled on the falling edge; tb_h/tb_v hold the raster position of the sampled cycle.
// Backpressure: IO requester holds io_req until io_ack, then drops it or re-presents.
module tb_vga_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_req;
  logic [15:0] io_addr;
  logic [7:0]  io_data;
  logic        io_ack;
  logic        vga_hs, vga_vs, vga_de;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;

  int checks = 0;
  int errors = 0;
  int tb_h = 0;
  int tb_v = 0;

  bit [7:0] ram [65536];

  vga_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .io_req   (io_req),
    .io_addr  (io_addr),
    .io_data  (io_data),
    .io_ack   (io_ack),
    .vga_hs   (vga_hs),
    .vga_vs   (vga_vs),
    .vga_r    (vga_r),
    .vga_g    (vga_g),
    .vga_b    (vga_b),
    .vga_de   (vga_de)
  );

  always #20 clk = ~clk;

  // Framebuffer RAM port B: registered read, write on mem_we; seeded with test pixels during reset.
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_din;
    if (rst) begin
      ram[16'h8000] <= 8'hE0;
      ram[16'h8001] <= 8'h1C;
      ram[16'h809F] <= 8'hFF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at v=%0d h=%0d: observed=0x%0h expected=0x%0h", tag, tb_v, tb_h, obs, exp);
    end
  endtask

  // One clock: advance the bench's raster position the way the spec defines it, then sample point.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      tb_h = 0;
      tb_v = 0;
    end else if (tb_h == 799) begin
      tb_h = 0;
      tb_v = (tb_v == 524) ? 0 : tb_v + 1;
    end else begin
      tb_h = tb_h + 1;
    end
    @(negedge clk);
  endtask

  task automatic wait_hv(input int v, input int h);
    int n;
    n = 0;
    while (!(tb_v == v && tb_h == h) && n < 430000) begin
      tick();
      n++;
    end
    if (!(tb_v == v && tb_h == h)) begin
      checks++;
      errors++;
      $error("FAIL wait_hv timeout: observed v=%0d h=%0d required v=%0d h=%0d", tb_v, tb_h, v, h);
    end
  endtask

  function automatic logic [8:0] px();
    return {vga_de, vga_r, vga_g, vga_b};
  endfunction

  initial begin
    int lows;
    int first;
    int early;
    int nw;

    rst = 1'b1;
    io_req = 1'b0;
    io_addr = '0;
    io_data = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_mem", {7'd0, mem_we, mem_din, mem_addr}, 32'd0);
    chk("rst_ack", {31'd0, io_ack}, 32'd0);
    chk("rst_vga", {vga_hs, vga_vs, px()}, {2'b11, 9'h000});
    rst = 1'b0;

    // Line 0: address sequence and first pixels (pixel p appears at h=p+3)
    for (int h = 1; h <= 10; h++) begin
      wait_hv(0, h);
      if (h <= 4) chk("l0_addr_a", {16'd0, mem_addr}, 32'h8000);
      else if (h <= 8) chk("l0_addr_b", {16'd0, mem_addr}, 32'h8001);
      if (h == 2) chk("l0_pre_de", {23'd0, px()}, 32'h000);
      else if (h >= 3 && h <= 6) chk("l0_px_red", {23'd0, px()}, 32'h1E0);
      else if (h >= 7) chk("l0_px_green", {23'd0, px()}, 32'h11C);
    end

    // Pixel 639 is active; next cycle is blank and rgb forced 0 though RAM still returns 0xFF
    wait_hv(0, 642);
    chk("l0_last_px", {23'd0, px()}, 32'h1FF);
    wait_hv(0, 643);
    chk("l0_blank_rgb", {23'd0, px()}, 32'h000);

    // hsync: one full line window, low for 96 clks starting at h=659
    wait_hv(0, 799);
    lows = 0;
    first = -1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (!vga_hs) begin
        lows++;
        if (first < 0) first = tb_h;
      end
    end
    chk("hs_first_low", first, 659);
    chk("hs_width", lows, 96);

    // Row stepping every 4 lines
    wait_hv(3, 640);
    chk("row3_last", {16'd0, mem_addr}, 32'h809F);
    wait_hv(4, 1);
    chk("row4_base", {16'd0, mem_addr}, 32'h80A0);

    // IO write requested mid-line waits for blanking (decided at h=640, visible at h=641)
    wait_hv(10, 100);
    io_req = 1'b1;
    io_addr = 16'h8005;
    io_data = 8'h03;
    early = 0;
    for (int i = 0; i < 540; i++) begin
      tick();
      if (io_ack || mem_we) early++;
    end
    chk("io_no_early", early, 0);
    tick();
    chk("io_write", {6'd0, io_ack, mem_we, mem_addr, mem_din}, {6'd0, 2'b11, 16'h8005, 8'h03});
    io_req = 1'b0;
    tick();
    chk("io_single", {30'd0, io_ack, mem_we}, 32'd0);

    // Jump to the last framebuffer row to reach the frame end quickly
    wait_hv(10, 700);
    force dut.u_tg.v_q = 10'd476;
    force dut.row_base_q = 15'd19040;
    tb_v = 476;
    tick();
    release dut.u_tg.v_q;
    release dut.row_base_q;
    wait_hv(479, 640);
    chk("last_fetch", {16'd0, mem_addr}, 32'hCAFF);
    wait_hv(479, 641);
    chk("blank_hold", {16'd0, mem_addr}, 32'hCAFF);

    // Skip to the last line so the v wrap clears row_base
    wait_hv(480, 700);
    force dut.u_tg.v_q = 10'd524;
    tb_v = 524;
    tick();
    release dut.u_tg.v_q;
    wait_hv(0, 1);
    chk("wrap_fetch", {16'd0, mem_addr}, 32'h8000);

    // Written byte at 0x8005 covers pixels 20-23 of lines 0-3
    for (int v = 0; v < 4; v++) begin
      wait_hv(v, 23);
      chk("io_px20", {23'd0, px()}, 32'h103);
      wait_hv(v, 26);
      chk("io_px23", {23'd0, px()}, 32'h103);
      wait_hv(v, 27);
      chk("io_px24", {23'd0, px()}, 32'h100);
    end

    // One-cycle reset with an IO request pending
    wait_hv(3, 200);
    io_req = 1'b1;
    io_addr = 16'h0200;
    io_data = 8'hAA;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstp_mem", {7'd0, mem_we, mem_din, mem_addr}, 32'd0);
    chk("rstp_ack", {31'd0, io_ack}, 32'd0);
    chk("rstp_vga", {vga_hs, vga_vs, px()}, {2'b11, 9'h000});
    tick();
    chk("rstp_restart", {14'd0, mem_we, io_ack, mem_addr}, 32'h8000);
    io_req = 1'b0;

    // vsync around lines 490-491
    wait_hv(0, 700);
    force dut.u_tg.v_q = 10'd488;
    tb_v = 488;
    tick();
    release dut.u_tg.v_q;
    wait_hv(490, 2);
    chk("vs_before", {31'd0, vga_vs}, 32'd1);
    wait_hv(490, 3);
    chk("vs_start", {31'd0, vga_vs}, 32'd0);
    wait_hv(492, 2);
    chk("vs_end", {31'd0, vga_vs}, 32'd0);
    wait_hv(492, 3);
    chk("vs_after", {31'd0, vga_vs}, 32'd1);

    // Continuous request in vertical blanking: write every other clock
    wait_hv(500, 100);
    io_req = 1'b1;
    io_addr = 16'h0100;
    io_data = 8'h55;
    nw = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (mem_we) nw++;
      chk("burst_ack", {30'd0, io_ack, mem_we}, (k % 2 == 1) ? 32'd3 : 32'd0);
    end
    io_req = 1'b0;
    tick();
    chk("burst_count", nw, 5);
    chk("burst_ram", {24'd0, ram[16'h0100]}, 32'h55);
    chk("rst_dropped_ram", {24'd0, ram[16'h0200]}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
